// File: rtl/fifo_rx_frame_decoder.sv
// fifo_rx_frame_decoder
// Polls fifo_interface for received bytes one at a time, deframes fixed
// 5-byte command packets (SYNC, CMD, ARG_H, ARG_L, CHK) and presents each
// validated command as a one-cycle strobe with held command/argument values.
// CHK is the XOR of CMD, ARG_H and ARG_L.
module fifo_rx_frame_decoder #(
  parameter int unsigned POLL_INTERVAL = 438,
  parameter int unsigned RX_TIMEOUT    = 64,
  parameter int unsigned FRAME_TIMEOUT = 36000,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        rx_poll_o,
  input  logic        rx_data_rdy_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_err_i,
  input  logic        busy_i,
  output logic        cmd_valid_o,
  output logic [7:0]  cmd_o,
  output logic [15:0] arg_o,
  output logic        chk_err_o,
  output logic        frame_err_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int PT_W = $clog2(POLL_INTERVAL + 1);
  localparam int WT_W = $clog2(RX_TIMEOUT + 1);
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [PT_W-1:0] POLL_LAST  = PT_W'(POLL_INTERVAL - 1);
  localparam logic [WT_W-1:0] WAIT_LAST  = WT_W'(RX_TIMEOUT - 1);
  localparam logic [FT_W-1:0] FRAME_LAST = FT_W'(FRAME_TIMEOUT - 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetchState_e;

  typedef enum logic [2:0] {
    P_HUNT,
    P_CMD,
    P_ARGH,
    P_ARGL,
    P_CHK
  } parseState_e;

  fetchState_e       fetchState_q;
  parseState_e       parseState_q;
  logic [PT_W-1:0]   pollTimer_q;
  logic [WT_W-1:0]   waitTimer_q;
  logic [FT_W-1:0]   frameTimer_q;
  logic              rxPoll_q;

  logic [7:0]        cmdByte_q;
  logic [7:0]        argH_q;
  logic [7:0]        argL_q;
  logic [7:0]        cmd_q;
  logic [15:0]       arg_q;
  logic              cmdValid_q;
  logic              chkErr_q;
  logic              frameErr_q;
  logic [7:0]        frameCnt_q;

  logic              byteAccept;
  logic              inFrame;
  logic [7:0]        chkCalc;

  // A byte only counts when it answers our own outstanding poll; stray strobes are dropped.
  assign byteAccept = (fetchState_q == F_WAIT) && rx_data_rdy_i;
  assign inFrame    = (parseState_q != P_HUNT);
  assign chkCalc    = cmdByte_q ^ argH_q ^ argL_q;

  // Fetch FSM: pace polls while hunting, poll back-to-back inside a frame, one poll in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fetchState_q <= F_IDLE;
      pollTimer_q  <= '0;
      waitTimer_q  <= '0;
      rxPoll_q     <= 1'b0;
    end else begin
      rxPoll_q <= 1'b0;
      case (fetchState_q)
        F_IDLE: begin
          if (inFrame || (pollTimer_q == POLL_LAST)) begin
            pollTimer_q  <= '0;
            fetchState_q <= F_REQ;
          end else begin
            pollTimer_q <= pollTimer_q + PT_W'(1);
          end
        end
        F_REQ: begin
          if (!busy_i) begin
            rxPoll_q     <= 1'b1;
            waitTimer_q  <= '0;
            fetchState_q <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (rx_data_rdy_i || rx_err_i || (waitTimer_q == WAIT_LAST)) begin
            fetchState_q <= F_IDLE;
          end else begin
            waitTimer_q <= waitTimer_q + WT_W'(1);
          end
        end
        default: fetchState_q <= F_IDLE;
      endcase
    end
  end

  // Parse FSM plus inter-byte frame timer; an accepted byte always beats a coincident timeout.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      parseState_q <= P_HUNT;
      frameTimer_q <= '0;
      cmdByte_q    <= '0;
      argH_q       <= '0;
      argL_q       <= '0;
      cmd_q        <= '0;
      arg_q        <= '0;
      cmdValid_q   <= 1'b0;
      chkErr_q     <= 1'b0;
      frameErr_q   <= 1'b0;
      frameCnt_q   <= '0;
    end else begin
      cmdValid_q <= 1'b0;
      chkErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
      if (byteAccept) begin
        frameTimer_q <= '0;
        case (parseState_q)
          P_HUNT: begin
            if (rx_data_i == SYNC_BYTE) begin
              parseState_q <= P_CMD;
            end
          end
          P_CMD: begin
            cmdByte_q    <= rx_data_i;
            parseState_q <= P_ARGH;
          end
          P_ARGH: begin
            argH_q       <= rx_data_i;
            parseState_q <= P_ARGL;
          end
          P_ARGL: begin
            argL_q       <= rx_data_i;
            parseState_q <= P_CHK;
          end
          P_CHK: begin
            if (rx_data_i == chkCalc) begin
              cmd_q      <= cmdByte_q;
              arg_q      <= {argH_q, argL_q};
              cmdValid_q <= 1'b1;
              frameCnt_q <= frameCnt_q + 8'd1;
            end else begin
              chkErr_q <= 1'b1;
            end
            parseState_q <= P_HUNT;
          end
          default: parseState_q <= P_HUNT;
        endcase
      end else if (inFrame) begin
        if (frameTimer_q == FRAME_LAST) begin
          frameErr_q   <= 1'b1;
          frameTimer_q <= '0;
          parseState_q <= P_HUNT;
        end else begin
          frameTimer_q <= frameTimer_q + FT_W'(1);
        end
      end else begin
        frameTimer_q <= '0;
      end
    end
  end

  assign rx_poll_o   = rxPoll_q;
  assign cmd_valid_o = cmdValid_q;
  assign cmd_o       = cmd_q;
  assign arg_o       = arg_q;
  assign chk_err_o   = chkErr_q;
  assign frame_err_o = frameErr_q;
  assign frame_cnt_o = frameCnt_q;

endmodule

// File: tb/tb_fifo_rx_frame_decoder.sv
// tb_fifo_rx_frame_decoder
// Drives fifo_rx_frame_decoder with a modelled fifo_interface responder and
// compares its outputs against a byte-stream reference model of the framing rules.
module tb_fifo_rx_frame_decoder;

  localparam int          POLL_INTERVAL = 20;
  localparam int          RX_TIMEOUT    = 16;
  localparam int          FRAME_TIMEOUT = 200;
  localparam int          RESP_LAT      = 3;
  localparam logic [7:0]  SYNC          = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        rx_poll_o;
  logic        rx_data_rdy_i;
  logic [7:0]  rx_data_i;
  logic        rx_err_i;
  logic        busy_i;
  logic        cmd_valid_o;
  logic [7:0]  cmd_o;
  logic [15:0] arg_o;
  logic        chk_err_o;
  logic        frame_err_o;
  logic [7:0]  frame_cnt_o;

  fifo_rx_frame_decoder #(
    .POLL_INTERVAL(POLL_INTERVAL),
    .RX_TIMEOUT   (RX_TIMEOUT),
    .FRAME_TIMEOUT(FRAME_TIMEOUT),
    .SYNC_BYTE    (SYNC)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .rx_poll_o    (rx_poll_o),
    .rx_data_rdy_i(rx_data_rdy_i),
    .rx_data_i    (rx_data_i),
    .rx_err_i     (rx_err_i),
    .busy_i       (busy_i),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_o        (cmd_o),
    .arg_o        (arg_o),
    .chk_err_o    (chk_err_o),
    .frame_err_o  (frame_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Host byte stream: main sequence appends, responder consumes via its own read pointer
  logic [7:0] byteQ[$];
  int         rdPtr = 0;
  int         respBusy = 0;
  int         dataTimes[$];
  int         pollTimes[$];

  // Monitor counters
  int validCnt = 0;
  int chkCnt = 0;
  int ferrCnt = 0;
  int exclViol = 0;
  int validLat = 0;
  int ferrCycle = 0;

  // Reference model state
  logic [7:0]  modelBuf[$];
  int          modelValid = 0;
  int          modelChk = 0;
  int          modelFerr = 0;
  logic [7:0]  modelCmd = 8'h00;
  logic [15:0] modelArg = 16'h0000;
  logic [7:0]  modelCnt = 8'h00;

  int errors = 0;
  int checks = 0;
  int sv, sc, sf, mv, mc, mf;

  // Responder: answers each poll RESP_LAT cycles later with the next byte, or an error if none is queued
  initial begin : responder
    rx_data_rdy_i = 1'b0;
    rx_err_i      = 1'b0;
    rx_data_i     = 8'h00;
    forever begin
      @(negedge clk);
      if (rx_poll_o === 1'b1) begin
        respBusy = 1;
        repeat (RESP_LAT) @(negedge clk);
        if (rdPtr < byteQ.size()) begin
          rx_data_i     = byteQ[rdPtr];
          rdPtr         = rdPtr + 1;
          rx_data_rdy_i = 1'b1;
          dataTimes.push_back(cycle);
        end else begin
          rx_err_i = 1'b1;
        end
        @(negedge clk);
        rx_data_rdy_i = 1'b0;
        rx_err_i      = 1'b0;
        respBusy      = 0;
      end
    end
  end

  // Monitor: tallies output strobes and poll times away from the active edge
  always @(negedge clk) begin
    if (rx_poll_o === 1'b1) pollTimes.push_back(cycle);
    if (cmd_valid_o === 1'b1) begin
      validCnt <= validCnt + 1;
      if (dataTimes.size() > 0) validLat <= cycle - dataTimes[$];
    end
    if (chk_err_o === 1'b1) chkCnt <= chkCnt + 1;
    if (frame_err_o === 1'b1) begin
      ferrCnt   <= ferrCnt + 1;
      ferrCycle <= cycle;
    end
    if ((int'(cmd_valid_o) + int'(chk_err_o) + int'(frame_err_o)) > 1) exclViol <= exclViol + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Model: scan the stream, discard non-sync bytes, judge each complete 5-byte frame
  task automatic modelAdvance();
    while (modelBuf.size() > 0) begin
      if (modelBuf[0] != SYNC) begin
        void'(modelBuf.pop_front());
        continue;
      end
      if (modelBuf.size() < 5) break;
      if ((modelBuf[1] ^ modelBuf[2] ^ modelBuf[3]) == modelBuf[4]) begin
        modelValid++;
        modelCmd = modelBuf[1];
        modelArg = {modelBuf[2], modelBuf[3]};
        modelCnt = modelCnt + 8'd1;
      end else begin
        modelChk++;
      end
      repeat (5) void'(modelBuf.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    byteQ.push_back(b);
    modelBuf.push_back(b);
    modelAdvance();
  endtask

  task automatic sendFrame(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al, input logic [7:0] ck);
    applyStimulus(SYNC);
    applyStimulus(c);
    applyStimulus(ah);
    applyStimulus(al);
    applyStimulus(ck);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((rdPtr < byteQ.size() || respBusy != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checkOutput({tag, "_drained"}, 64'(n < 20000), 64'(1));
  endtask

  task automatic snap();
    sv = validCnt; sc = chkCnt; sf = ferrCnt;
    mv = modelValid; mc = modelChk; mf = modelFerr;
  endtask

  task automatic checkDeltas(input string tag);
    checkOutput({tag, "_valid_pulses"}, 64'(validCnt - sv), 64'(modelValid - mv));
    checkOutput({tag, "_chk_pulses"}, 64'(chkCnt - sc), 64'(modelChk - mc));
    checkOutput({tag, "_ferr_pulses"}, 64'(ferrCnt - sf), 64'(modelFerr - mf));
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_cmd"}, 64'(cmd_o), 64'(modelCmd));
    checkOutput({tag, "_arg"}, 64'(arg_o), 64'(modelArg));
    checkOutput({tag, "_cnt"}, 64'(frame_cnt_o), 64'(modelCnt));
  endtask

  task automatic checkPollSpacing(input string tag);
    int p0, minGap, n;
    p0 = pollTimes.size();
    repeat (5 * (POLL_INTERVAL + 8)) @(negedge clk);
    n = pollTimes.size() - p0;
    minGap = 1000000;
    for (int i = p0 + 1; i < pollTimes.size(); i++)
      if (pollTimes[i] - pollTimes[i-1] < minGap) minGap = pollTimes[i] - pollTimes[i-1];
    checkOutput({tag, "_poll_count_ge3"}, 64'(n >= 3), 64'(1));
    checkOutput({tag, "_min_gap_ge_interval"}, 64'(minGap >= POLL_INTERVAL), 64'(1));
  endtask

  // Watchdog so the run always ends
  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int idx, n, maxGap, nGarb;
    logic [7:0] gb, c, ah, al, ck;

    reset_ni = 1'b0;
    busy_i   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 64'({rx_poll_o, cmd_valid_o, chk_err_o, frame_err_o, cmd_o, arg_o, frame_cnt_o}), 64'(0));
    reset_ni = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_outputs", 64'({rx_poll_o, cmd_valid_o, chk_err_o, frame_err_o, cmd_o, arg_o, frame_cnt_o}), 64'(0));

    // Valid frame: checksum 10^12^34 = 36
    snap();
    idx = dataTimes.size();
    sendFrame(8'h10, 8'h12, 8'h34, 8'h36);
    waitDrain("frame1");
    checkDeltas("frame1");
    checkHeld("frame1");
    checkOutput("frame1_valid_latency", 64'(validLat), 64'(1));
    maxGap = 0;
    for (int i = idx + 1; i < idx + 5 && i < dataTimes.size(); i++)
      if (dataTimes[i] - dataTimes[i-1] > maxGap) maxGap = dataTimes[i] - dataTimes[i-1];
    checkOutput("frame1_fast_polls", 64'(maxGap > 0 && maxGap < POLL_INTERVAL), 64'(1));

    // Bad checksum: previous command stays on the outputs
    snap();
    sendFrame(8'h10, 8'h12, 8'h34, 8'h37);
    waitDrain("badchk");
    checkDeltas("badchk");
    checkHeld("badchk");

    // Leading garbage before a frame
    snap();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    sendFrame(8'h01, 8'h00, 8'h02, 8'h03);
    waitDrain("garbage");
    checkDeltas("garbage");
    checkHeld("garbage");

    // Frame stalls after CMD; every later poll fails until the frame timer fires
    snap();
    applyStimulus(SYNC);
    applyStimulus(8'h10);
    n = 0;
    while (ferrCnt == sf && n < FRAME_TIMEOUT * 4) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    modelBuf.delete();
    modelFerr++;
    checkDeltas("timeout");
    checkOutput("timeout_delay", 64'((ferrCycle - dataTimes[$]) >= FRAME_TIMEOUT &&
                                     (ferrCycle - dataTimes[$]) <= FRAME_TIMEOUT + 1), 64'(1));
    checkPollSpacing("after_timeout");
    snap();
    sendFrame(8'h20, 8'h00, 8'h01, 8'h21);
    waitDrain("post_timeout");
    checkDeltas("post_timeout");
    checkHeld("post_timeout");

    // busy_i holds off the poll until it drops
    busy_i = 1'b1;
    idx = cycle;
    repeat (POLL_INTERVAL + 110) @(negedge clk);
    n = 0;
    foreach (pollTimes[i]) if (pollTimes[i] > idx) n++;
    checkOutput("busy_no_poll", 64'(n), 64'(0));
    checkOutput("busy_poll_low", 64'(rx_poll_o), 64'(0));
    busy_i = 1'b0;
    @(negedge clk);
    checkOutput("busy_release_poll", 64'(rx_poll_o), 64'(1));
    @(negedge clk);
    checkOutput("poll_single_cycle", 64'(rx_poll_o), 64'(0));

    // Idle FIFO: hunting polls respect the interval
    checkPollSpacing("idle");

    // Randomized frames with interleaved non-sync garbage and occasional bad checksums
    snap();
    for (int f = 0; f < 12; f++) begin
      nGarb = int'($urandom_range(0, 2));
      for (int g = 0; g < nGarb; g++) begin
        gb = 8'($urandom_range(0, 255));
        if (gb == SYNC) gb = 8'h00;
        applyStimulus(gb);
      end
      c  = 8'($urandom_range(0, 255));
      ah = 8'($urandom_range(0, 255));
      al = 8'($urandom_range(0, 255));
      ck = c ^ ah ^ al;
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      sendFrame(c, ah, al, ck);
    end
    waitDrain("random");
    checkDeltas("random");
    checkHeld("random");

    // Async reset between ARG_H and ARG_L; the late response must be ignored
    snap();
    idx = dataTimes.size();
    applyStimulus(SYNC);
    applyStimulus(8'h30);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    n = 0;
    while (dataTimes.size() < idx + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    while (rx_poll_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset_poll_seen", 64'(n < 2000), 64'(1));
    #3 reset_ni = 1'b0;
    #1;
    checkOutput("midframe_reset_outputs", 64'({rx_poll_o, cmd_valid_o, chk_err_o, frame_err_o, cmd_o, arg_o, frame_cnt_o}), 64'(0));
    @(negedge clk);
    reset_ni = 1'b1;
    modelBuf.delete();
    modelCmd = 8'h00;
    modelArg = 16'h0000;
    modelCnt = 8'h00;
    waitDrain("late_resp");
    checkDeltas("late_resp");
    checkHeld("late_resp");
    snap();
    sendFrame(8'h40, 8'h56, 8'h78, 8'h6E);
    waitDrain("fresh");
    checkDeltas("fresh");
    checkHeld("fresh");

    checkOutput("strobe_exclusive", 64'(exclViol), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
